// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of the single SDRAM controller port.
// Accepted reads are tagged with the requester ID so returning data is routed back in order.
module sdram_port_arbiter #(
  parameter int MAX_BURST   = 4,
  parameter int MAX_PENDING = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        p0_read_i,
  input  logic        p0_write_i,
  input  logic [24:0] p0_address_i,
  input  logic [15:0] p0_write_data_i,
  input  logic [1:0]  p0_byteenable_n_i,
  output logic        p0_wait_request_o,
  output logic [15:0] p0_read_data_o,
  output logic        p0_data_valid_o,
  input  logic        p1_read_i,
  input  logic        p1_write_i,
  input  logic [24:0] p1_address_i,
  input  logic [15:0] p1_write_data_i,
  input  logic [1:0]  p1_byteenable_n_i,
  output logic        p1_wait_request_o,
  output logic [15:0] p1_read_data_o,
  output logic        p1_data_valid_o,
  output logic        chipselect_o,
  output logic        write_n_o,
  output logic        read_n_o,
  output logic [1:0]  byteenable_n_o,
  output logic [24:0] address_o,
  output logic [15:0] write_data_o,
  input  logic [15:0] read_data_i,
  input  logic        wait_request_i,
  input  logic        data_validation_i,
  output logic [1:0]  grant_o,
  output logic        tag_error_o
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;

  logic [1:0]       req_rd, req_wr, req_any;
  logic [1:0][24:0] req_addr;
  logic [1:0][15:0] req_wd;
  logic [1:0][1:0]  req_be;

  logic       own, sel, sel_rd, sel_wr, blocked, accept, push, pop;
  logic [1:0] wait_vec;

  logic [MAX_PENDING-1:0] tag_mem_q;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [PW:0]            occ_q;
  logic                   full, empty, pop_tag;

  logic [1:0]       valid_q, valid_d;
  logic [1:0][15:0] rdata_q;
  logic             tag_err_q;

  assign req_rd   = {p1_read_i, p0_read_i};
  assign req_wr   = {p1_write_i, p0_write_i};
  assign req_any  = req_rd | req_wr;
  assign req_addr = {p1_address_i, p0_address_i};
  assign req_wd   = {p1_write_data_i, p0_write_data_i};
  assign req_be   = {p1_byteenable_n_i, p0_byteenable_n_i};

  assign own     = |state_q;
  assign sel     = state_q[1];
  assign full    = (occ_q == (PW+1)'(MAX_PENDING));
  assign empty   = (occ_q == '0);
  assign pop_tag = tag_mem_q[rptr_q];

  // Output process: downstream mirrors the owner, reads stall while the tag FIFO is full.
  always_comb begin
    sel_rd         = own & req_rd[sel];
    sel_wr         = own & req_wr[sel];
    blocked        = sel_rd & full;
    chipselect_o   = sel_wr | (sel_rd & ~full);
    read_n_o       = ~(sel_rd & ~full);
    write_n_o      = ~sel_wr;
    byteenable_n_o = own ? req_be[sel]   : 2'b11;
    address_o      = own ? req_addr[sel] : '0;
    write_data_o   = own ? req_wd[sel]   : '0;
    wait_vec       = 2'b11;
    if (own) wait_vec[sel] = wait_request_i | blocked;
  end

  assign accept = chipselect_o & ~wait_request_i;
  assign push   = accept & sel_rd;
  assign pop    = data_validation_i & ~empty;

  // Next-state process.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_any == 2'b11)  state_d = last_q ? OWN0 : OWN1;
        else if (req_any[0])   state_d = OWN0;
        else if (req_any[1])   state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req_any[sel]) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = sel;
        end else if (accept) begin
          if (cnt_q == BW'(MAX_BURST-1)) begin
            cnt_d = '0;
            if (req_any[!sel]) begin
              state_d = sel ? OWN0 : OWN1;
              last_d  = sel;
            end
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 2'b00;
    if (pop) valid_d[pop_tag] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      valid_q   <= '0;
      rdata_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      occ_q   <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
      valid_q <= valid_d;
      if (pop) rdata_q[pop_tag] <= read_data_i;
      if (data_validation_i && empty) tag_err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; only the pointers define validity.
  always_ff @(posedge clock_i) begin
    if (push) tag_mem_q[wptr_q] <= sel;
  end

  assign grant_o           = state_q;
  assign p0_wait_request_o = wait_vec[0];
  assign p1_wait_request_o = wait_vec[1];
  assign p0_data_valid_o   = valid_q[0];
  assign p1_data_valid_o   = valid_q[1];
  assign p0_read_data_o    = rdata_q[0];
  assign p1_read_data_o    = rdata_q[1];
  assign tag_error_o       = tag_err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared
// against a queue-based behavioural model of the arbiter.
module tb_sdram_port_arbiter;
  localparam int MAXB = 4;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p_rd[2], p_wr[2];
  logic [24:0] p_ad[2];
  logic [15:0] p_wd[2];
  logic [1:0]  p_be[2];
  logic        w0, w1, v0, v1;
  logic [15:0] rdat0, rdat1;
  logic        cs, wn, rn, terr;
  logic [1:0]  dbe, grant;
  logic [24:0] dad;
  logic [15:0] dwd, rdata;
  logic        wreq, dv;

  sdram_port_arbiter #(.MAX_BURST(MAXB), .MAX_PENDING(MAXP)) dut (
    .clock_i(clk), .reset_i(rst),
    .p0_read_i(p_rd[0]), .p0_write_i(p_wr[0]), .p0_address_i(p_ad[0]),
    .p0_write_data_i(p_wd[0]), .p0_byteenable_n_i(p_be[0]),
    .p0_wait_request_o(w0), .p0_read_data_o(rdat0), .p0_data_valid_o(v0),
    .p1_read_i(p_rd[1]), .p1_write_i(p_wr[1]), .p1_address_i(p_ad[1]),
    .p1_write_data_i(p_wd[1]), .p1_byteenable_n_i(p_be[1]),
    .p1_wait_request_o(w1), .p1_read_data_o(rdat1), .p1_data_valid_o(v1),
    .chipselect_o(cs), .write_n_o(wn), .read_n_o(rn), .byteenable_n_o(dbe),
    .address_o(dad), .write_data_o(dwd), .read_data_i(rdata),
    .wait_request_i(wreq), .data_validation_i(dv),
    .grant_o(grant), .tag_error_o(terr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { bit wr; logic [24:0] ad; logic [15:0] wd; logic [1:0] be; } req_t;
  typedef struct { int cyc; logic [1:0] g; bit wr; logic [24:0] ad; } acc_t;

  req_t rq[2][$];
  acc_t acc_log[$];
  bit   act[2];
  bit   samp_wait[2];
  bit   samp_rst;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  // Requester model: hold each request until it is seen accepted, then take the next.
  always @(posedge clk) begin
    req_t r;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (samp_rst) act[n] = 0;
      else if (act[n] && !samp_wait[n]) act[n] = 0;
      if (!act[n] && rq[n].size() > 0) begin
        r = rq[n].pop_front();
        p_rd[n] = !r.wr; p_wr[n] = r.wr; p_ad[n] = r.ad; p_wd[n] = r.wd; p_be[n] = r.be;
        act[n] = 1;
      end
      if (!act[n]) begin p_rd[n] = 0; p_wr[n] = 0; end
    end
  end

  // Reference model: owner/burst/last-served as integers, outstanding read tags in a queue.
  int         mown = -1, mcnt = 0, mlast = 1;
  int         mq[$];
  bit         mv[2];
  logic [15:0] mr[2];
  bit         mterr = 0, seen = 0;

  always @(negedge clk) begin
    int o, t;
    bit rd, wr, full, blk, acc, r0, r1;
    logic [45:0] eb;
    logic [1:0]  ew, eg;
    o    = mown;
    rd   = (o >= 0) ? p_rd[o] : 1'b0;
    wr   = (o >= 0) ? p_wr[o] : 1'b0;
    full = (mq.size() == MAXP);
    blk  = rd && full;
    if (seen) begin
      eb = {wr || (rd && !full), !(rd && !full), !wr,
            (o >= 0) ? p_be[o] : 2'b11, (o >= 0) ? p_ad[o] : 25'd0, (o >= 0) ? p_wd[o] : 16'd0};
      chk("bus", {cs, rn, wn, dbe, dad, dwd}, eb);
      ew[0] = (o == 0) ? (wreq || blk) : 1'b1;
      ew[1] = (o == 1) ? (wreq || blk) : 1'b1;
      chk("wait", {w1, w0}, ew);
      eg = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
      chk("grant", grant, eg);
      chk("valid", {v1, v0}, {mv[1], mv[0]});
      chk("rdata0", rdat0, mr[0]);
      chk("rdata1", rdat1, mr[1]);
      chk("tag_error", terr, mterr);
    end
    samp_wait[0] = w0; samp_wait[1] = w1; samp_rst = rst;
    if (!rst && cs && !wreq) acc_log.push_back('{cyc, grant, !wn, dad});
    if (rst) begin
      seen = 1; mown = -1; mcnt = 0; mlast = 1; mq.delete();
      mv[0] = 0; mv[1] = 0; mr[0] = '0; mr[1] = '0; mterr = 0;
    end else begin
      acc = (wr || (rd && !full)) && !wreq;
      mv[0] = 0; mv[1] = 0;
      if (dv) begin
        if (mq.size() > 0) begin t = mq.pop_front(); mv[t] = 1; mr[t] = rdata; end
        else mterr = 1;
      end
      if (acc && rd) mq.push_back(o);
      if (o < 0) begin
        r0 = p_rd[0] || p_wr[0];
        r1 = p_rd[1] || p_wr[1];
        if (r0 && r1) mown = (mlast == 1) ? 0 : 1;
        else if (r0)  mown = 0;
        else if (r1)  mown = 1;
      end else if (!(p_rd[o] || p_wr[o])) begin
        mlast = o; mown = -1; mcnt = 0;
      end else if (acc) begin
        if (mcnt == MAXB-1) begin
          mcnt = 0;
          if (p_rd[1-o] || p_wr[1-o]) begin mlast = o; mown = 1 - o; end
        end else mcnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rst_dut();
    rst = 1; rq[0].delete(); rq[1].delete(); wreq = 0; dv = 0;
    tick(1);
    rst = 0;
    tick(1);
    acc_log.delete();
  endtask

  task automatic push(input int n, input bit wr, input logic [24:0] ad, input logic [15:0] wd);
    req_t r;
    r.wr = wr; r.ad = ad; r.wd = wd; r.be = 2'($urandom);
    rq[n].push_back(r);
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit; i++) begin
      if (rq[0].size() == 0 && rq[1].size() == 0 && !act[0] && !act[1]) begin done = 1; break; end
      tick(1);
    end
    chk("drain_done", done, 1);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      p_rd[n] = 0; p_wr[n] = 0; p_ad[n] = '0; p_wd[n] = '0; p_be[n] = 2'b11;
    end
    wreq = 0; dv = 0; rdata = '0;
    tick(2);
    rst = 0;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_cs", cs, 0);
    chk("rst_rw_n", {rn, wn}, 2'b11);
    chk("rst_wait", {w1, w0}, 2'b11);
    chk("rst_terr", terr, 0);

    // Single port write burst
    rst_dut();
    for (int i = 0; i < 3; i++) push(0, 1, 25'h10 + 25'(i), 16'($urandom));
    drain(60);
    chk("t1_count", acc_log.size(), 3);
    for (int i = 0; i < acc_log.size() && i < 3; i++) begin
      chk("t1_grant", acc_log[i].g, 2'b01);
      chk("t1_wr", acc_log[i].wr, 1);
      chk("t1_addr", acc_log[i].ad, 25'h10 + 25'(i));
    end
    @(negedge clk);
    chk("t1_idle", grant, 2'b00);

    // Fairness with both ports streaming
    tick(1);
    rst_dut();
    for (int i = 0; i < 12; i++) begin
      push(0, 1, 25'h1000 + 25'(i), 16'($urandom));
      push(1, 1, 25'h2000 + 25'(i), 16'($urandom));
    end
    drain(200);
    chk("t2_count", acc_log.size(), 24);
    for (int i = 0; i < acc_log.size() && i < 24; i++) begin
      chk("t2_port", acc_log[i].g, ((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) chk("t2_gap", acc_log[i].cyc - acc_log[i-1].cyc, 1);
    end

    // Read routing
    rst_dut();
    push(0, 0, 25'h100, 16'h0);
    push(1, 0, 25'h200, 16'h0);
    drain(40);
    dv = 1; rdata = 16'hAAAA;
    tick(1);
    rdata = 16'h5555;
    @(negedge clk);
    chk("t3_v_a", {v1, v0}, 2'b01);
    chk("t3_d_a", rdat0, 16'hAAAA);
    tick(1);
    dv = 0;
    @(negedge clk);
    chk("t3_v_b", {v1, v0}, 2'b10);
    chk("t3_d_b", rdat1, 16'h5555);
    chk("t3_hold", rdat0, 16'hAAAA);

    // Tag FIFO full
    tick(1);
    rst_dut();
    for (int i = 0; i < 9; i++) push(1, 0, 25'h300 + 25'(i), 16'h0);
    tick(20);
    chk("t4_count8", acc_log.size(), 8);
    @(negedge clk);
    chk("t4_block", {w1, rn, cs}, 3'b110);
    tick(1);
    dv = 1; rdata = 16'h1234;
    tick(1);
    dv = 0;
    @(negedge clk);
    chk("t4_release", {w1, rn, cs}, 3'b001);
    tick(1);
    chk("t4_count9", acc_log.size(), 9);

    // Stall on controller wait_request
    rst_dut();
    wreq = 1;
    push(0, 1, 25'h40, 16'hBEEF);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_wait", w0, 1);
      chk("t5_noacc", acc_log.size(), 0);
      tick(1);
    end
    wreq = 0;
    drain(20);
    chk("t5_single", acc_log.size(), 1);

    // Tag error and reset mid-burst
    rst_dut();
    dv = 1; tick(1); dv = 0;
    @(negedge clk);
    chk("t6_terr", terr, 1);
    tick(3);
    @(negedge clk);
    chk("t6_sticky", terr, 1);
    tick(1);
    for (int i = 0; i < 3; i++) push(0, 0, 25'h500 + 25'(i), 16'h0);
    for (int i = 0; i < 3; i++) push(0, 1, 25'h600 + 25'(i), 16'($urandom));
    for (int i = 0; i < 50 && acc_log.size() < 3; i++) tick(1);
    chk("t6_reads", acc_log.size(), 3);
    rst = 1; rq[0].delete(); rq[1].delete();
    tick(1);
    rst = 0;
    @(negedge clk);
    chk("t6_grant", grant, 2'b00);
    chk("t6_cs", cs, 0);
    chk("t6_terr_clr", terr, 0);
    tick(2);
    dv = 1; tick(1); dv = 0;
    @(negedge clk);
    chk("t6_late_rsp", terr, 1);

    // Random traffic against the model
    tick(1);
    rst_dut();
    for (int c = 0; c < 2000; c++) begin
      wreq  = ($urandom % 4 == 0);
      dv    = (mq.size() > 0 && $urandom % 3 == 0) || ($urandom % 200 == 0);
      rdata = 16'($urandom);
      for (int n = 0; n < 2; n++)
        if (rq[n].size() < 2 && $urandom % 3 != 0)
          push(n, 1'($urandom), 25'($urandom), 16'($urandom));
      if (c == 1000) rst = 1;
      if (c == 1001) rst = 0;
      tick(1);
    end
    wreq = 0; dv = 0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
